// File: rtl/allo_queue_if.sv
// Host/controller-side signal bundle for the allophone queue.
// The queue sits on the slave modport; the host/controller model drives the master side.
interface allo_queue_if #(
    parameter int AW = 4
);
    logic [5:0]  wr_data;
    logic        wr_stb;
    logic        flush;
    logic        ldq;
    logic [5:0]  data_out;
    logic        data_stb;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        busy;
    logic        overflow;
    logic        hs_err;

    modport slave (
        input  wr_data, wr_stb, flush, ldq,
        output data_out, data_stb, full, empty, count, busy, overflow, hs_err
    );

    modport master (
        output wr_data, wr_stb, flush, ldq,
        input  data_out, data_stb, full, empty, count, busy, overflow, hs_err
    );
endinterface

// File: rtl/allo_queue.sv
// Allophone FIFO feeding the Speech256 controller through its ldq/data_stb handshake,
// with occupancy, busy and sticky overflow/handshake-watchdog status for the host.
module allo_queue #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int WD_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst_an,
    allo_queue_if.slave    bus
);

    typedef enum logic [1:0] {
        S_READY,
        S_STROBE,
        S_WAIT_DROP
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]  WD_LIMIT   = 8'(WD_CYCLES);

    state_t        state_q, state_d;
    logic [7:0]    wd_q, wd_d;
    logic          wd_expire;

    logic [5:0]    mem_q [DEPTH];
    logic [5:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [5:0]    data_out_q, data_out_d;
    logic          overflow_q, overflow_d;
    logic          hs_err_q, hs_err_d;

    logic          pop;
    logic          push;
    logic          drop;
    logic          is_full;
    logic          is_empty;

    assign is_full  = (count_q == FULL_COUNT);
    assign is_empty = (count_q == '0);

    // A pop only launches from S_READY, so at most one allophone is in flight.
    assign pop  = (state_q == S_READY) && bus.ldq && !is_empty && !bus.flush;
    assign push = bus.wr_stb && !bus.flush && (!is_full || pop);
    assign drop = bus.wr_stb && !bus.flush && is_full && !pop;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q <= S_READY;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // FSM: next state and handshake watchdog
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        wd_expire = 1'b0;
        case (state_q)
            S_READY: begin
                if (pop) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                wd_d    = '0;
                state_d = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!bus.ldq) begin
                    state_d = S_READY;
                end else begin
                    if (wd_q != 8'hFF) begin
                        wd_d = wd_q + 8'd1;
                    end
                    if (wd_d >= WD_LIMIT) begin
                        wd_expire = 1'b1;
                        state_d   = S_READY;
                    end
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.data_stb = (state_q == S_STROBE);
        bus.busy     = !is_empty || (state_q != S_READY);
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
            hs_err_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
            hs_err_q   <= hs_err_d;
        end
    end

    // Flush wins over writes and pops but leaves data_out and the FSM alone,
    // so an allophone already strobed stays delivered.
    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        overflow_d = overflow_q;
        hs_err_d   = hs_err_q;

        if (bus.flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            hs_err_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = bus.wr_data;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop) begin
                data_out_d = mem_q[rptr_q];
                rptr_d     = rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (wd_expire) begin
                hs_err_d = 1'b1;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.overflow = overflow_q;
    assign bus.hs_err   = hs_err_q;

endmodule

// File: tb/tb_allo_queue.sv
// Directed bench for allo_queue: reset, delivery, ordering, full/overflow, watchdog and flush.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_allo_queue;

    logic clk;
    logic rst_an;
    int   total;
    int   bad;

    allo_queue_if #(.AW(4)) bus ();

    allo_queue #(
        .DEPTH(16),
        .AW(4),
        .WD_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_an(rst_an),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int strobes;
        rst_an       = 1'b0;
        bus.ldq      = 1'b1;
        bus.wr_stb   = 1'b0;
        bus.wr_data  = 6'h00;
        bus.flush    = 1'b0;
        repeat (3) step();
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.data_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", bus.data_stb); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if ({bus.full, bus.overflow, bus.hs_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.full, bus.overflow, bus.hs_err}); end
        total++; if (bus.data_out !== 6'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data_out); end
        rst_an  = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.data_stb === 1'b1) strobes++;
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL idle_strobes got=%0d want=0", strobes); end
    endtask

    task automatic test_single();
        bus.ldq     = 1'b1;
        bus.wr_data = 6'h2A;
        bus.wr_stb  = 1'b1;
        step();
        bus.wr_stb  = 1'b0;
        total++; if (bus.data_stb !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b want=0", bus.data_stb); end
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", bus.count); end
        step();
        total++; if (bus.data_stb !== 1'b1) begin bad++; $display("FAIL single_stb got=%b want=1", bus.data_stb); end
        total++; if (bus.data_out !== 6'h2A) begin bad++; $display("FAIL single_data got=%h want=2a", bus.data_out); end
        step();
        total++; if (bus.data_stb !== 1'b0) begin bad++; $display("FAIL single_stb_width got=%b want=0", bus.data_stb); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_wait got=%b want=1", bus.busy); end
        bus.ldq = 1'b0;
        step();
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", bus.count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle got=%b want=0", bus.busy); end
    endtask

    task automatic test_order();
        int strobes;
        bus.ldq = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.wr_data = 6'(i);
            bus.wr_stb  = 1'b1;
            step();
        end
        bus.wr_stb = 1'b0;
        total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL order_count3 got=%0d want=3", bus.count); end
        for (int k = 0; k < 3; k++) begin
            bus.ldq = 1'b1;
            step();
            bus.ldq = 1'b0;
            total++; if (bus.data_stb !== 1'b1) begin bad++; $display("FAIL order_stb%0d got=%b want=1", k, bus.data_stb); end
            total++; if (bus.data_out !== 6'(k + 1)) begin bad++; $display("FAIL order_data%0d got=%h want=%h", k, bus.data_out, 6'(k + 1)); end
            total++; if (bus.count !== 5'(2 - k)) begin bad++; $display("FAIL order_count%0d got=%0d want=%0d", k, bus.count, 2 - k); end
            strobes = 0;
            for (int c = 0; c < 39; c++) begin
                step();
                if (bus.data_stb === 1'b1) strobes++;
            end
            total++; if (strobes !== 0) begin bad++; $display("FAIL order_extra%0d got=%0d want=0", k, strobes); end
        end
    endtask

    task automatic test_full();
        logic [5:0] want;
        bus.ldq = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = (i < 16) ? 6'(8'h10 + i) : 6'h20;
            bus.wr_stb  = 1'b1;
            step();
            if (i == 15) begin
                total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_early got=%b want=0", bus.overflow); end
            end
        end
        bus.wr_stb = 1'b0;
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", bus.full); end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", bus.count); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b want=1", bus.overflow); end
        bus.ldq     = 1'b1;
        bus.wr_data = 6'h30;
        bus.wr_stb  = 1'b1;
        step();
        bus.ldq    = 1'b0;
        bus.wr_stb = 1'b0;
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fullpop_count got=%0d want=16", bus.count); end
        total++; if (bus.data_out !== 6'h10 || bus.data_stb !== 1'b1) begin bad++; $display("FAIL fullpop_data got=%h/%b want=10/1", bus.data_out, bus.data_stb); end
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            want    = (i < 15) ? 6'(8'h11 + i) : 6'h30;
            bus.ldq = 1'b1;
            step();
            bus.ldq = 1'b0;
            total++; if (bus.data_stb !== 1'b1 || bus.data_out !== want) begin bad++; $display("FAIL drain%0d got=%h/%b want=%h/1", i, bus.data_out, bus.data_stb, want); end
            step();
            step();
        end
        total++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d want=1/0", bus.empty, bus.count); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b want=0", bus.overflow); end
    endtask

    task automatic test_watchdog();
        bus.ldq = 1'b0;
        bus.wr_stb = 1'b1;
        bus.wr_data = 6'h05;
        step();
        bus.wr_data = 6'h06;
        step();
        bus.wr_stb = 1'b0;
        bus.ldq    = 1'b1;
        step();
        total++; if (bus.data_stb !== 1'b1 || bus.data_out !== 6'h05) begin bad++; $display("FAIL wd_first got=%h/%b want=05/1", bus.data_out, bus.data_stb); end
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if (bus.hs_err !== (k == 8)) begin bad++; $display("FAIL wd_hs_err%0d got=%b want=%b", k, bus.hs_err, k == 8); end
            total++; if (bus.data_stb !== 1'b0) begin bad++; $display("FAIL wd_nostb%0d got=%b want=0", k, bus.data_stb); end
        end
        step();
        total++; if (bus.data_stb !== 1'b1 || bus.data_out !== 6'h06) begin bad++; $display("FAIL wd_next got=%h/%b want=06/1", bus.data_out, bus.data_stb); end
        total++; if (bus.hs_err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b want=1", bus.hs_err); end
        bus.ldq = 1'b0;
        step();
        step();
    endtask

    task automatic test_flush();
        int strobes;
        bus.ldq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 6'(8'h0A + i);
            bus.wr_stb  = 1'b1;
            step();
        end
        bus.wr_stb = 1'b0;
        bus.ldq    = 1'b1;
        step();
        total++; if (bus.data_stb !== 1'b1 || bus.data_out !== 6'h0A) begin bad++; $display("FAIL flush_stb got=%h/%b want=0a/1", bus.data_out, bus.data_stb); end
        total++; if (bus.count !== 5'd4) begin bad++; $display("FAIL flush_pre_count got=%0d want=4", bus.count); end
        bus.flush = 1'b1;
        bus.ldq   = 1'b0;
        step();
        bus.flush = 1'b0;
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL flush_cleared got=%0d/%b want=0/1", bus.count, bus.empty); end
        total++; if (bus.hs_err !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_flags got=%b%b want=00", bus.hs_err, bus.overflow); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_keeps_fsm got=%b want=1", bus.busy); end
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b want=0", bus.busy); end
        bus.ldq = 1'b1;
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.data_stb === 1'b1) strobes++;
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL flush_no_more got=%0d want=0", strobes); end
        bus.ldq = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_order();
        test_full();
        test_watchdog();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
